// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MUL_WAIT = 2'd1, MEM_WAIT = 2'd2} state_e;
  // Which stall/flush pattern drives the pipeline controls this cycle.
  typedef enum logic [2:0] {ACT_NONE, ACT_MEM, ACT_MUL, ACT_BR, ACT_LU} act_e;
  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MUL_LAT_DEF = 4;
endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  output logic       hazard
);
  // r0 is hardwired zero, so a load into it never creates a dependency.
  assign hazard = ex_memread && (ex_rt != REG_ZERO) &&
                  ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use, branch flush,
// multi-cycle multiply occupancy of EX and data-memory wait, plus a stall counter.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mul_start,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             exmem_bubble,
  output logic             memwb_en,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int              MC_W     = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [MC_W-1:0] MUL_INIT = MC_W'(MUL_LAT - 2);

  state_e           state_q, state_d, ret_state_q, ret_state_d, eff_state;
  logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             lu_hazard, mem_stall, mul_busy;
  act_e             act;

  load_use_detect u_lu (
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .hazard(lu_hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      ret_state_q    <= RUN;
      mul_cnt_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      ret_state_q    <= ret_state_d;
      mul_cnt_q      <= mul_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // On the release cycle of a memory wait the saved state's rules apply.
  always_comb begin
    eff_state = (state_q == MEM_WAIT) ? ret_state_q : state_q;
    mem_stall = (state_q == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
    mul_busy  = (eff_state == MUL_WAIT) ? (mul_cnt_q != '0) : ex_mul_start;
    act = ACT_NONE;
    if (rst)                  act = ACT_NONE;
    else if (mem_stall)       act = ACT_MEM;
    else if (mul_busy)        act = ACT_MUL;
    else if (ex_branch_taken) act = ACT_BR;
    else if (lu_hazard)       act = ACT_LU;
  end

  always_comb begin
    state_d        = state_q;
    ret_state_d    = ret_state_q;
    mul_cnt_d      = mul_cnt_q;
    stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, ~pc_en};
    case (act)
      ACT_MEM: begin
        if (state_q != MEM_WAIT) ret_state_d = state_q;
        state_d = MEM_WAIT;
      end
      ACT_MUL: begin
        mul_cnt_d = (eff_state == MUL_WAIT) ? mul_cnt_q - MC_W'(1) : MUL_INIT;
        state_d   = MUL_WAIT;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    exmem_bubble = 1'b0;
    memwb_en     = 1'b1;
    memwb_bubble = 1'b0;
    case (act)
      ACT_MEM: begin
        pc_en = 1'b0; ifid_en = 1'b0; idex_en = 1'b0; exmem_en = 1'b0;
        memwb_bubble = 1'b1;
      end
      ACT_MUL: begin
        pc_en = 1'b0; ifid_en = 1'b0; idex_en = 1'b0;
        exmem_bubble = 1'b1;
      end
      ACT_BR: begin
        ifid_flush = 1'b1; idex_bubble = 1'b1;
      end
      ACT_LU: begin
        pc_en = 1'b0; ifid_en = 1'b0; idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_cycles = stall_cycles_q;
endmodule
